// File: rtl/cache_defs.sv
// Shared cache-subsystem types for the application-memory burst responder.
// Holds the responder FSM state type and the burst-length limits.
package cache_defs;

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST,
    WAIT_REL
  } type_burst_resp_state_e;

  localparam int BURST_MAX_BL = 512;
  localparam int BL_W = $clog2(BURST_MAX_BL) + 1;

endpackage

// File: rtl/app_mem_burst_resp.sv
// Wishbone burst responder in front of a single-port SRAM with 1-cycle reads.
// One ack per beat, last-ack on the final beat, err pulse on bl=0.
module app_mem_burst_resp
  import cache_defs::*;
#(
  parameter int WB_AW  = 32,
  parameter int WB_DW  = 32,
  parameter int MEM_AW = 9
) (
  input  logic              mclk,
  input  logic              rst,
  input  logic              wb_stb_i,
  input  logic [WB_AW-1:0]  wb_adr_i,
  input  logic              wb_we_i,
  input  logic [WB_DW-1:0]  wb_dat_i,
  input  logic [3:0]        wb_sel_i,
  input  logic [BL_W-1:0]   wb_bl_i,
  output logic [WB_DW-1:0]  wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_lack_o,
  output logic              wb_err_o,
  output logic              mem_csb0,
  output logic              mem_web0,
  output logic [MEM_AW-1:0] mem_addr0,
  output logic [3:0]        mem_wmask0,
  output logic [WB_DW-1:0]  mem_din0,
  input  logic [WB_DW-1:0]  mem_dout0
);

  type_burst_resp_state_e state, state_nx;

  logic [BL_W-1:0]   issue_cnt, beat_cnt, bl_q;
  logic [MEM_AW-1:0] adr_q, wr_addr;
  logic [3:0]        sel_q, wr_mask;
  logic [WB_DW-1:0]  wr_data;
  logic              rd_vld, rd_issue, rd_last, wr_pend;
  logic              unused_adr;

  assign unused_adr = ^{wb_adr_i[WB_AW-1:MEM_AW+2], wb_adr_i[1:0]};
  assign rd_last = rd_vld && (beat_cnt == bl_q - BL_W'(1));

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (wb_stb_i) begin
          if (wb_bl_i == '0)  state_nx = WAIT_REL;
          else if (wb_we_i)   state_nx = WR_BURST;
          else                state_nx = RD_BURST;
        end
      end
      RD_BURST: begin
        if (!wb_stb_i)    state_nx = IDLE;
        else if (rd_last) state_nx = WAIT_REL;
      end
      WR_BURST: begin
        if (!wb_stb_i)      state_nx = IDLE;
        else if (wb_lack_o) state_nx = WAIT_REL;
      end
      WAIT_REL: begin
        if (!wb_stb_i) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Reads go straight to the macro; writes trail their ack by one cycle.
  always_comb begin
    rd_issue   = (state == RD_BURST) && wb_stb_i && (issue_cnt < bl_q);
    mem_csb0   = 1'b1;
    mem_web0   = 1'b1;
    mem_addr0  = '0;
    mem_wmask0 = '0;
    mem_din0   = '0;
    if (rd_issue) begin
      mem_csb0  = 1'b0;
      mem_addr0 = adr_q + issue_cnt[MEM_AW-1:0];
    end else if (wr_pend) begin
      mem_csb0   = 1'b0;
      mem_web0   = 1'b0;
      mem_addr0  = wr_addr;
      mem_wmask0 = wr_mask;
      mem_din0   = wr_data;
    end
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      issue_cnt <= '0;
      beat_cnt  <= '0;
      bl_q      <= '0;
      adr_q     <= '0;
      sel_q     <= '0;
      rd_vld    <= 1'b0;
      wr_pend   <= 1'b0;
      wr_addr   <= '0;
      wr_mask   <= '0;
      wr_data   <= '0;
      wb_dat_o  <= '0;
      wb_ack_o  <= 1'b0;
      wb_lack_o <= 1'b0;
      wb_err_o  <= 1'b0;
    end else begin
      wb_ack_o  <= 1'b0;
      wb_lack_o <= 1'b0;
      wb_err_o  <= 1'b0;
      wr_pend   <= 1'b0;
      rd_vld    <= rd_issue;
      case (state)
        IDLE: begin
          if (wb_stb_i) begin
            if (wb_bl_i == '0) begin
              wb_err_o <= 1'b1;
            end else begin
              issue_cnt <= '0;
              beat_cnt  <= '0;
              bl_q      <= wb_bl_i;
              adr_q     <= wb_adr_i[MEM_AW+1:2];
              sel_q     <= wb_sel_i;
              wb_ack_o  <= wb_we_i;
              wb_lack_o <= wb_we_i && (wb_bl_i == BL_W'(1));
            end
          end
        end
        RD_BURST: begin
          if (rd_issue) issue_cnt <= issue_cnt + BL_W'(1);
          // A falling stb discards whatever read is still in flight.
          if (wb_stb_i && rd_vld) begin
            wb_dat_o  <= mem_dout0;
            wb_ack_o  <= 1'b1;
            wb_lack_o <= rd_last;
            beat_cnt  <= beat_cnt + BL_W'(1);
          end
        end
        WR_BURST: begin
          if (wb_stb_i) begin
            wr_pend   <= 1'b1;
            wr_addr   <= adr_q + beat_cnt[MEM_AW-1:0];
            wr_data   <= wb_dat_i;
            wr_mask   <= sel_q;
            beat_cnt  <= beat_cnt + BL_W'(1);
            wb_ack_o  <= !wb_lack_o;
            wb_lack_o <= !wb_lack_o && (beat_cnt + BL_W'(2) == bl_q);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
